cpu_regfile_wr_arbiter: RTL and testbench



---
 rtl/cpu_rf_pkg.sv | 14 +
 rtl/cpu_rr_arb2.sv | 32 +++
 rtl/cpu_regfile_wr_arbiter.sv | 104 ++++++++++
 tb/tb_cpu_regfile_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared types and constants for the register file write-port sequencer.
package cpu_rf_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;

   typedef enum logic {INIT, RUN} rf_arb_state_t;
   typedef enum logic {EX, LD} rf_req_t;

   function automatic logic [RF_ADDR_W-1:0] rf_last_reg(input logic half);
      return half ? 5'd15 : 5'd31;
   endfunction

endpackage

// File: rtl/cpu_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = EX, bit 1 = LD.
module cpu_rr_arb2
   import cpu_rf_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_rdy,
   output logic [1:0] o_gnt,
   output logic       o_upd
);

   rf_req_t last_grant_q;

   // Ready does not depend on the requester's own valid, so upstream may use it freely.
   always_comb begin
      o_rdy[0] = i_en & (~i_req[1] | (last_grant_q == LD));
      o_rdy[1] = i_en & (~i_req[0] | (last_grant_q == EX));
      o_gnt    = o_rdy & i_req;
      o_upd    = |o_gnt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_grant_q <= LD;
      end else if (o_upd) begin
         last_grant_q <= o_gnt[1] ? LD : EX;
      end
   end

endmodule

// File: rtl/cpu_regfile_wr_arbiter.sv
// Write-port sequencer/arbiter for the 2R1W register file.
// ASTERISC_RF_CLEAR_EN compiles in the post-reset clear of x1..x31 (x1..x15 in half mode).
module cpu_regfile_wr_arbiter
   import cpu_rf_pkg::*;
#(
   parameter bit p_half_regfile = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_ex_valid,
   output logic                 o_ex_ready,
   input  logic [RF_ADDR_W-1:0] i_ex_addr,
   input  logic [RF_DATA_W-1:0] i_ex_data,
   input  logic                 i_ld_valid,
   output logic                 o_ld_ready,
   input  logic [RF_ADDR_W-1:0] i_ld_addr,
   input  logic [RF_DATA_W-1:0] i_ld_data,
   output logic                 o_wr_en,
   output logic [RF_ADDR_W-1:0] o_wr_addr,
   output logic [RF_DATA_W-1:0] o_wr_data,
   output logic                 o_busy,
   output logic                 o_addr_oob
);

   logic                 clr_active;
   logic [RF_ADDR_W-1:0] clr_addr;

`ifdef ASTERISC_RF_CLEAR_EN
   rf_arb_state_t        state_q;
   logic [RF_ADDR_W-1:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= INIT;
         cnt_q   <= 5'd1;
      end else if (state_q == INIT) begin
         if (cnt_q == rf_last_reg(p_half_regfile)) begin
            state_q <= RUN;
         end
         cnt_q <= cnt_q + 5'd1;
      end
   end

   assign clr_active = (state_q == INIT);
   assign clr_addr   = cnt_q;
`else
   assign clr_active = 1'b0;
   assign clr_addr   = '0;
`endif

   logic [1:0]           gnt;
   logic [1:0]           rdy;
   logic                 upd;
   logic [RF_ADDR_W-1:0] req_addr;
   logic [RF_DATA_W-1:0] req_data;
   logic                 req_oob;

   cpu_rr_arb2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (~i_rst & ~clr_active),
      .i_req ({i_ld_valid, i_ex_valid}),
      .o_rdy (rdy),
      .o_gnt (gnt),
      .o_upd (upd)
   );

   assign o_ex_ready = rdy[0];
   assign o_ld_ready = rdy[1];
   assign o_busy     = clr_active;

   assign req_addr = gnt[1] ? i_ld_addr : i_ex_addr;
   assign req_data = gnt[1] ? i_ld_data : i_ex_data;
   assign req_oob  = p_half_regfile & req_addr[4];

   // Address/data hold their last value when no write is issued.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wr_en    <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         o_addr_oob <= 1'b0;
      end else begin
         o_wr_en    <= 1'b0;
         o_addr_oob <= 1'b0;
         if (clr_active) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= clr_addr;
            o_wr_data <= '0;
         end else if (upd) begin
            if (req_addr == '0) begin
               o_wr_en <= 1'b0;
            end else if (req_oob) begin
               o_addr_oob <= 1'b1;
            end else begin
               o_wr_en   <= 1'b1;
               o_wr_addr <= req_addr;
               o_wr_data <= req_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu_regfile_wr_arbiter.sv
// Bench for cpu_regfile_wr_arbiter: full (index 0) and half (index 1) instances share stimulus.
module tb_cpu_regfile_wr_arbiter;
   import cpu_rf_pkg::*;

`ifdef ASTERISC_RF_CLEAR_EN
   localparam bit ClrEn = 1'b1;
`else
   localparam bit ClrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ld_valid;
   logic [4:0]  ex_addr, ld_addr;
   logic [31:0] ex_data, ld_data;

   logic [1:0]  ex_rdy, ld_rdy, wr_en, busy, oob;
   logic [4:0]  wr_addr [2];
   logic [31:0] wr_data [2];

   int n_checks = 0;
   int n_err    = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   cpu_regfile_wr_arbiter #(.p_half_regfile(1'b0)) u_full (
      .i_clk(clk), .i_rst(rst),
      .i_ex_valid(ex_valid), .o_ex_ready(ex_rdy[0]), .i_ex_addr(ex_addr), .i_ex_data(ex_data),
      .i_ld_valid(ld_valid), .o_ld_ready(ld_rdy[0]), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
      .o_wr_en(wr_en[0]), .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0]),
      .o_busy(busy[0]), .o_addr_oob(oob[0])
   );

   cpu_regfile_wr_arbiter #(.p_half_regfile(1'b1)) u_half (
      .i_clk(clk), .i_rst(rst),
      .i_ex_valid(ex_valid), .o_ex_ready(ex_rdy[1]), .i_ex_addr(ex_addr), .i_ex_data(ex_data),
      .i_ld_valid(ld_valid), .o_ld_ready(ld_rdy[1]), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
      .o_wr_en(wr_en[1]), .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1]),
      .o_busy(busy[1]), .o_addr_oob(oob[1])
   );

   // Register file driven by the full instance; x0 reads as 0 unless something writes it.
   logic [31:0] rf0 [32];
   always @(posedge clk) begin
      if (rst) rf0[0] <= 32'h0;
      else if (wr_en[0]) rf0[wr_addr[0]] <= wr_data[0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: clr_next = next register to clear (0 = clearing done), last = 0 EX / 1 LD.
   logic [4:0]  m_clr_next [2];
   logic        m_last     [2];
   logic        m_en       [2];
   logic [4:0]  m_addr     [2];
   logic [31:0] m_data     [2];
   logic        m_oob      [2];

   always @(posedge clk) begin : model
      int          win;
      logic [4:0]  a;
      logic [31:0] d;
      logic [4:0]  lastreg;
      for (int h = 0; h < 2; h++) begin
         lastreg = (h == 1) ? 5'd15 : 5'd31;
         win = -1;
         if (rst) begin
            m_clr_next[h] <= ClrEn ? 5'd1 : 5'd0;
            m_last[h]     <= 1'b1;
            m_en[h]       <= 1'b0;
            m_addr[h]     <= 5'd0;
            m_data[h]     <= 32'd0;
            m_oob[h]      <= 1'b0;
         end else begin
            m_en[h]  <= 1'b0;
            m_oob[h] <= 1'b0;
            if (m_clr_next[h] != 5'd0) begin
               m_en[h]       <= 1'b1;
               m_addr[h]     <= m_clr_next[h];
               m_data[h]     <= 32'd0;
               m_clr_next[h] <= (m_clr_next[h] == lastreg) ? 5'd0 : m_clr_next[h] + 5'd1;
            end else begin
               if (ex_valid && ld_valid) win = (m_last[h] == 1'b0) ? 1 : 0;
               else if (ex_valid)        win = 0;
               else if (ld_valid)        win = 1;
               if (win >= 0) begin
                  a = (win == 1) ? ld_addr : ex_addr;
                  d = (win == 1) ? ld_data : ex_data;
                  m_last[h] <= (win == 1);
                  if (a == 5'd0) begin
                     m_en[h] <= 1'b0;
                  end else if (h == 1 && a >= 5'd16) begin
                     m_oob[h] <= 1'b1;
                  end else begin
                     m_en[h]   <= 1'b1;
                     m_addr[h] <= a;
                     m_data[h] <= d;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic e_busy, e_exr, e_ldr;
      if (chk_on) begin
         for (int h = 0; h < 2; h++) begin
            e_busy = (m_clr_next[h] != 5'd0);
            e_exr  = !rst && !e_busy && (!ld_valid || m_last[h] == 1'b1);
            e_ldr  = !rst && !e_busy && (!ex_valid || m_last[h] == 1'b0);
            chk($sformatf("busy[%0d]", h),     {31'd0, busy[h]},   {31'd0, e_busy});
            chk($sformatf("ex_ready[%0d]", h), {31'd0, ex_rdy[h]}, {31'd0, e_exr});
            chk($sformatf("ld_ready[%0d]", h), {31'd0, ld_rdy[h]}, {31'd0, e_ldr});
            chk($sformatf("wr_en[%0d]", h),    {31'd0, wr_en[h]},  {31'd0, m_en[h]});
            chk($sformatf("wr_addr[%0d]", h),  {27'd0, wr_addr[h]}, {27'd0, m_addr[h]});
            chk($sformatf("wr_data[%0d]", h),  wr_data[h],          m_data[h]);
            chk($sformatf("addr_oob[%0d]", h), {31'd0, oob[h]},    {31'd0, m_oob[h]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic observe_clear(output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      repeat (34) begin
         @(negedge clk);
         if (wr_en[0]) c0++;
         if (wr_en[1]) c1++;
         step();
      end
   endtask

   initial begin : stim
      int         c0, c1;
      logic [3:0] g0, g1;
      rst = 1'b1;
      ex_valid = 1'b0; ld_valid = 1'b0;
      ex_addr = 5'd0; ld_addr = 5'd0; ex_data = 32'd0; ld_data = 32'd0;

      // Reset values
      step();
      chk_on = 1'b1;
      @(negedge clk);
      chk("rst wr_en", {31'd0, wr_en[0]}, 32'd0);
      chk("rst wr_addr", {27'd0, wr_addr[0]}, 32'd0);
      chk("rst ex_ready", {31'd0, ex_rdy[0]}, 32'd0);
      chk("rst busy", {31'd0, busy[0]}, {31'd0, ClrEn});
      step();
      rst = 1'b0;

      // Clear sequence length
      observe_clear(c0, c1);
      chk("clear writes full", c0, ClrEn ? 32'd31 : 32'd0);
      chk("clear writes half", c1, ClrEn ? 32'd15 : 32'd0);

      // Conflict: both valid for 4 cycles
      ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 32'hA000_0001;
      ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'hB000_0002;
      g0 = 4'bxxxx;
      g1 = 4'bxxxx;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ex_rdy[0]) g0[i] = 1'b0; else if (ld_rdy[0]) g0[i] = 1'b1;
         if (ex_rdy[1]) g1[i] = 1'b0; else if (ld_rdy[1]) g1[i] = 1'b1;
         chk("both ready full", {31'd0, ex_rdy[0] & ld_rdy[0]}, 32'd0);
         step();
      end
      ex_valid = 1'b0; ld_valid = 1'b0;
      chk("grant order full", {28'd0, g0}, 32'h0000_000A);
      chk("grant order half", {28'd0, g1}, 32'h0000_000A);
      @(negedge clk);
      chk("last conflict write addr", {27'd0, wr_addr[0]}, 32'd2);
      step();

      // EX alone: write visible in N+1, readable in N+2
      ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ex alone ready", {31'd0, ex_rdy[0]}, 32'd1);
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("ex alone wr_en", {31'd0, wr_en[0]}, 32'd1);
      chk("ex alone wr_addr", {27'd0, wr_addr[0]}, 32'd5);
      chk("ex alone wr_data", wr_data[0], 32'hDEAD_BEEF);
      step();
      @(negedge clk);
      chk("read x5", rf0[5], 32'hDEAD_BEEF);
      step();

      // Write to x0 is swallowed
      ex_valid = 1'b1; ex_addr = 5'd0; ex_data = 32'h0000_1234;
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("x0 wr_en", {31'd0, wr_en[0]}, 32'd0);
      chk("x0 addr held", {27'd0, wr_addr[0]}, 32'd5);
      step();
      @(negedge clk);
      chk("read x0", rf0[0], 32'd0);
      step();

      // LD to x17: out of bounds only in half mode
      ld_valid = 1'b1; ld_addr = 5'd17; ld_data = 32'h0000_0077;
      step();
      ld_valid = 1'b0;
      @(negedge clk);
      chk("oob half wr_en", {31'd0, wr_en[1]}, 32'd0);
      chk("oob half pulse", {31'd0, oob[1]}, 32'd1);
      chk("oob full pulse", {31'd0, oob[0]}, 32'd0);
      chk("x17 full addr", {27'd0, wr_addr[0]}, 32'd17);
      step();
      @(negedge clk);
      chk("oob half pulse end", {31'd0, oob[1]}, 32'd0);
      step();

      // Reset in RUN drops the in-flight write
      ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'h0000_0707;
      step();
      ex_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("inflight wr_en", {31'd0, wr_en[0]}, 32'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("dropped wr_en", {31'd0, wr_en[0]}, 32'd0);

      // Reset at clear step 10 restarts the sequence
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      observe_clear(c0, c1);
      chk("restart writes full", c0, ClrEn ? 32'd31 : 32'd0);
      chk("restart writes half", c1, ClrEn ? 32'd15 : 32'd0);

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
